// File: rtl/seq_cont_pkg.sv
// Shared types for the procedural-vs-continuous output monitor.
package seq_cont_pkg;

    localparam int unsigned KIND_W   = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned STAMP_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } state_t;

    localparam logic [KIND_W-1:0] KIND_NONE = 2'b00;
    localparam logic [KIND_W-1:0] KIND_PROC = 2'b01;
    localparam logic [KIND_W-1:0] KIND_CONT = 2'b10;
    localparam logic [KIND_W-1:0] KIND_BOTH = 2'b11;

    // Record at the default stamp width; the top re-declares it at its own STAMP_W.
    typedef struct packed {
        logic [KIND_W-1:0]      kind;
        logic [STAMP_W_DEF-1:0] stamp;
    } ev_rec_t;

    // Bit 0 flags the procedural path, bit 1 the continuous path.
    function automatic logic [KIND_W-1:0] classify(input logic a, input logic p, input logic c);
        return {c != a, p != a};
    endfunction

endpackage

// File: rtl/seq_cont_fifo.sv
// Synchronous event FIFO; pointers carry a wrap bit to separate full from empty.
module seq_cont_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        // A push into a full FIFO only lands when the head leaves on the same edge.
        wr_en = push && (!full || pop);
        rd_en = pop && !empty;
        head  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/seq_cont_mon.sv
// Drives a stimulus bit, waits for settling, then flags disagreement of either output path.
module seq_cont_mon
    import seq_cont_pkg::*;
#(
    parameter int unsigned STAMP_W    = 16,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               a_in,
    input  logic               out_proc,
    input  logic               out_cont,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [KIND_W-1:0]  ev_kind,
    output logic [STAMP_W-1:0] ev_stamp,
    output logic [CNT_W-1:0]   mismatch_cnt,
    output logic               overflow
);

    localparam int unsigned REC_W = KIND_W + STAMP_W;

    typedef struct packed {
        logic [KIND_W-1:0]  kind;
        logic [STAMP_W-1:0] stamp;
    } rec_t;

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [STAMP_W-1:0]  stamp;
    logic [STAMP_W-1:0]  stamp_cap;
    logic                a_cap;

    logic [KIND_W-1:0]   kind_c;
    logic                push_c;
    logic                pop_c;
    logic                fifo_full;
    logic                fifo_empty;
    rec_t                push_rec_c;
    rec_t                head_rec;

    always_comb begin
        kind_c           = classify(a_cap, out_proc, out_cont);
        push_c           = (state == CHECK) && (kind_c != KIND_NONE);
        pop_c            = !fifo_empty && ev_ready;
        push_rec_c.kind  = kind_c;
        push_rec_c.stamp = stamp_cap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            settle_cnt   <= '0;
            stamp        <= '0;
            stamp_cap    <= '0;
            a_cap        <= 1'b0;
            mismatch_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_cap      <= a_in;
                        stamp_cap  <= stamp;
                        settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
                        state      <= SETTLE;
                        in_ready   <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= CHECK;
                    else                  settle_cnt <= settle_cnt - SETTLE_W'(1);
                end
                CHECK: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    // Dropped records still count as mismatches.
                    if (push_c) begin
                        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        if (fifo_full && !pop_c) overflow <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    seq_cont_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (push_rec_c),
        .pop       (pop_c),
        .head      (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        ev_valid = !fifo_empty;
        ev_kind  = head_rec.kind;
        ev_stamp = head_rec.stamp;
    end

endmodule

// File: tb/tb_seq_cont_mon.sv
// Directed bench for seq_cont_mon; popped event records are checked against a scoreboard queue.
module tb_seq_cont_mon;

    localparam int unsigned SC = 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] stamp;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        a_in;
    logic        out_proc;
    logic        out_cont;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_kind;
    logic [15:0] ev_stamp;
    logic [7:0]  mismatch_cnt;
    logic        overflow;

    logic [15:0] tb_stamp;
    rec_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    seq_cont_mon #(
        .STAMP_W    (16),
        .SETTLE_CYC (SC),
        .DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .out_proc     (out_proc),
        .out_cont     (out_cont),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_kind      (ev_kind),
        .ev_stamp     (ev_stamp),
        .mismatch_cnt (mismatch_cnt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference cycle count since the last reset edge.
    always @(posedge clk) begin
        if (!rst_n) tb_stamp <= '0;
        else        tb_stamp <= tb_stamp + 16'd1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: a head that will be popped on the coming edge must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_record", 32'(ev_valid), 32'd0);
            end else begin
                rec_t e;
                e = sb.pop_front();
                check("rec_kind",  32'(ev_kind),  32'(e.kind));
                check("rec_stamp", 32'(ev_stamp), 32'(e.stamp));
            end
        end
    end

    task automatic accept(input logic a, input logic p, input logic c,
                          input logic [1:0] kind, input bit drop, input bit rdy_at_check);
        int          n;
        logic [15:0] st;
        rec_t        r;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in     = a;
        out_proc = p;
        out_cont = c;
        st       = tb_stamp;
        @(posedge clk); #1;
        a_in = ~a;
        repeat (SC) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("busy_in_check", 32'(in_ready), 32'd0);
        if (sb.size() == 0) check("valid_before_push", 32'(ev_valid), 32'd0);
        if (rdy_at_check) ev_ready = 1'b1;
        @(posedge clk); #1;
        ev_ready = 1'b0;
        check("ready_after_check", 32'(in_ready), 32'd1);
        if (kind != 2'b00 && !drop) begin
            r.kind  = kind;
            r.stamp = st;
            sb.push_back(r);
        end
        if (kind != 2'b00)      check("valid_after_push", 32'(ev_valid), 32'd1);
        else if (sb.size() == 0) check("valid_no_push",   32'(ev_valid), 32'd0);
    endtask

    task automatic drain(output int pops);
        pops     = 0;
        ev_ready = 1'b1;
        while (ev_valid && pops < 20) begin
            @(posedge clk); #1;
            pops++;
        end
        ev_ready = 1'b0;
        check("drained_valid", 32'(ev_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int pops;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = 1'b0;
        out_proc = 1'b0;
        out_cont = 1'b0;
        ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_in_ready", 32'(in_ready),     32'd1);
        check("rst_ev_valid", 32'(ev_valid),     32'd0);
        check("rst_ev_kind",  32'(ev_kind),      32'd0);
        check("rst_ev_stamp", 32'(ev_stamp),     32'd0);
        check("rst_mcnt",     32'(mismatch_cnt), 32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);

        repeat (10) begin
            @(posedge clk); #1;
        end
        check("idle_in_ready", 32'(in_ready),     32'd1);
        check("idle_ev_valid", 32'(ev_valid),     32'd0);
        check("idle_mcnt",     32'(mismatch_cnt), 32'd0);

        // Procedural path disagrees, accepted at stamp 10.
        accept(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        check("a_kind",  32'(ev_kind),      32'd1);
        check("a_stamp", 32'(ev_stamp),     32'd10);
        check("a_mcnt",  32'(mismatch_cnt), 32'd1);
        drain(pops);
        check("a_pops", 32'(pops), 32'd1);

        // Both paths agree: nothing recorded.
        accept(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        check("b_mcnt",     32'(mismatch_cnt), 32'd1);
        check("b_ev_valid", 32'(ev_valid),     32'd0);

        // Five double mismatches with no consumer: four stored, fifth dropped.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("c_ovf_before_drop", 32'(overflow), 32'd0);
            accept(1'b1, 1'b0, 1'b0, 2'b11, (i == 4), 1'b0);
        end
        check("c_overflow", 32'(overflow),     32'd1);
        check("c_mcnt",     32'(mismatch_cnt), 32'd6);
        check("c_kind",     32'(ev_kind),      32'd3);
        drain(pops);
        check("c_pops",       32'(pops),     32'd4);
        check("c_ovf_sticky", 32'(overflow), 32'd1);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("r_overflow", 32'(overflow),     32'd0);
        check("r_mcnt",     32'(mismatch_cnt), 32'd0);

        // Occupancy 1 with simultaneous push and pop: new record becomes head.
        accept(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        accept(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        check("e_kind_new_head", 32'(ev_kind), 32'd2);
        accept(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        accept(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        accept(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        // Full FIFO with consumer ready on the push edge: no drop.
        accept(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        check("d_overflow", 32'(overflow),     32'd0);
        check("d_mcnt",     32'(mismatch_cnt), 32'd6);
        drain(pops);
        check("d_pops", 32'(pops), 32'd4);

        // Reset while SETTLE is pending abandons the check.
        in_valid = 1'b1;
        a_in     = 1'b1;
        out_proc = 1'b0;
        out_cont = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("f_in_settle", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("f_in_ready", 32'(in_ready),     32'd1);
        check("f_ev_valid", 32'(ev_valid),     32'd0);
        check("f_mcnt",     32'(mismatch_cnt), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("f_ev_valid_later", 32'(ev_valid),     32'd0);
        check("f_mcnt_later",     32'(mismatch_cnt), 32'd0);
        check("f_sb_empty",       32'(sb.size()),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_cont_mon.md
SEQ_CONT_MON -- requirements
Module: seq_cont_mon

Interface
REQ-001 Parameter STAMP_W, default 16, width of the cycle timestamp.
REQ-002 Parameter SETTLE_CYC, default 1, cycles waited after acceptance before sampling; legal range 1..15.
REQ-003 Parameter DEPTH, default 4, event FIFO depth; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 in_valid  input  1  stimulus value a_in is offered.
REQ-007 in_ready  output  1  block accepts a stimulus; high only in IDLE.
REQ-008 a_in  input  1  stimulus value driven into the device under observation.
REQ-009 out_proc  input  1  value from the procedural (always_comb) path.
REQ-010 out_cont  input  1  value from the continuous-assignment path.
REQ-011 ev_valid  output  1  event record available at the FIFO head.
REQ-012 ev_ready  input  1  consumer takes the head record.
REQ-013 ev_kind  output  2  head record kind: 01 = proc mismatch, 10 = cont mismatch, 11 = both.
REQ-014 ev_stamp  output  STAMP_W  head record timestamp.
REQ-015 mismatch_cnt  output  8  saturating count of detected mismatch events.
REQ-016 overflow  output  1  sticky flag; set when a record is dropped.

Function
REQ-017 Free-running stamp counter: +1 every cycle, wraps to 0 after 2^STAMP_W-1.
REQ-018 FSM states: IDLE, SETTLE, CHECK.
REQ-019 IDLE: when in_valid is high at an edge, capture a_in and the current stamp, load the settle counter with SETTLE_CYC-1, go to SETTLE.
REQ-020 SETTLE: decrement the settle counter each cycle; at 0, go to CHECK. Total SETTLE_CYC cycles are spent in SETTLE.
REQ-021 CHECK: one cycle; compare out_proc and out_cont with the captured a; form kind; go to IDLE unconditionally.
REQ-022 Acceptance at edge k gives the comparison sample at edge k+SETTLE_CYC+1; if a record is pushed, ev_valid is high from that edge onward.
REQ-023 A record is pushed only if kind != 00; a match pushes nothing and leaves mismatch_cnt unchanged.
REQ-024 Each non-zero kind increments mismatch_cnt once, saturating at 255. This includes dropped records.
REQ-025 FIFO holds records {kind, stamp}; ev_valid = not empty; the head is presented combinationally from FIFO storage.
REQ-026 A pop occurs when ev_valid and ev_ready are both high at an edge.
REQ-027 Push while full and no pop: drop the record, set overflow, leave contents unchanged.
REQ-028 Push and pop at the same edge while full: both take effect, occupancy stays DEPTH, overflow is not set.
REQ-029 Push and pop at the same edge while occupancy is 1: the new record becomes the head; ev_valid stays high.
REQ-030 in_valid in SETTLE or CHECK is ignored; a_in changes after capture do not affect the check.

Reset
REQ-031 With rst_n low at an edge: state IDLE, stamp 0, settle counter 0, FIFO empty, mismatch_cnt 0, overflow 0, captured a 0.
REQ-032 Reset values of outputs: in_ready 1 after reset; ev_valid 0; ev_kind 00; ev_stamp 0.
REQ-033 Reset asserted mid-SETTLE or mid-CHECK abandons the pending check; no record is pushed.
REQ-034 overflow and mismatch_cnt clear only by reset.

Structure
REQ-035 Package seq_cont_pkg holds the state enum (IDLE, SETTLE, CHECK), the kind encodings and a parameterised record struct {kind, stamp}.
REQ-036 Sub-module seq_cont_fifo: synchronous FIFO with DEPTH entries and a pointer wrap bit; full/empty derived from the pointers.

Verification
REQ-037 Reset then idle 10 cycles -> in_ready=1, ev_valid=0, mismatch_cnt=0, stamp advanced to 10.
REQ-038 SETTLE_CYC=1, accept a_in=1 at stamp 5, out_proc=0, out_cont=1 -> ev_valid rises 2 edges later, kind=01, ev_stamp=5, mismatch_cnt=1.
REQ-039 a_in=1 with both outputs 1 -> no record, mismatch_cnt unchanged, in_ready back to 1 after SETTLE_CYC+1 cycles.
REQ-040 ev_ready=0, 5 mismatching checks with both outputs 0 vs a_in=1 -> 4 records of kind=11, overflow=1, mismatch_cnt=5.
REQ-041 FIFO full, ev_ready=1 during a mismatching check -> occupancy stays 4, overflow stays 0, oldest record popped.
REQ-042 Reset asserted during SETTLE -> FIFO empty, mismatch_cnt=0, state IDLE at the next edge.
